adder_operand_sequencer: RTL
============================

# adder_operand_sequencer

- Clocked front-end for the combinational N-bit ripple adder.
- Captures operand A, operand B and carry-in from slide switches using a debounced "next" push-button.
- Drives the captured operands into the adder, then registers the adder's {carry, sum} for display.
- Optional built-in self-test sweeps every operand/carry combination and checks the adder output against a reference sum.

## Interface
Parameters:
- WIDTH, 3, operand width; must match the adder.
- DEBOUNCE_CYCLES, 16, cycles a synchronized button level must stay stable before it is accepted (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_in  in  WIDTH  operand switches.
- cin_sw  in  1  carry-in switch.
- btn_next  in  1  raw, asynchronous, active-high button.
- selftest_start  in  1  single-cycle start request; ignored unless OPSEQ_SELFTEST_EN is defined.
- a_out  out  WIDTH  operand A to adder, registered.
- b_out  out  WIDTH  operand B to adder, registered.
- cin_out  out  1  carry-in to adder, registered.
- sum_in  in  WIDTH  adder sum.
- cout_in  in  1  adder carry-out.
- result_out  out  WIDTH+1  registered {cout, sum}.
- result_valid  out  1  result_out holds a fresh result.
- state_out  out  3  current FSM state encoding, for LEDs.
- selftest_done  out  1  sweep complete (level, sticky until next start or reset).
- selftest_err  out  1  sticky mismatch flag.

## Operation
- Reset: every output is 0; state is LOAD_A; the debouncer counter is cleared.
- Button path:
  - btn_next passes through a 2-flop synchronizer.
  - The synchronized level must be stable for DEBOUNCE_CYCLES cycles.
  - A rising edge of the debounced level produces a one-cycle press pulse.
- States (state_out encoding):
  - LOAD_A=0: on press, a_out<=sw_in; go to LOAD_B.
  - LOAD_B=1: on press, b_out<=sw_in and cin_out<=cin_sw; go to SETTLE.
  - SETTLE=2: unconditionally, result_out<={cout_in,sum_in}, result_valid<=1; go to SHOW.
  - SHOW=3: on press, result_valid<=0; go to LOAD_A. a_out, b_out and cin_out keep their values until overwritten.
  - SELFTEST=4: sweep; only reachable when the macro is defined.
- Presses arriving in SETTLE or SELFTEST are dropped, not queued.
- Arithmetic: result_out is exactly the adder output. With WIDTH=3 the maximum is 7+7+1=15 (4'b1111). The sequencer performs no saturation.
- Reset asserted mid-operation returns immediately to LOAD_A with all outputs 0, including sticky self-test flags.

## Timing
- Press pulse: asserted DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+3 cycles after btn_next rises, if btn_next stays high.
- Operand registers load on the clock edge that ends the pulse cycle.
- result_valid rises one edge after the b_out load, i.e. 2 edges after the LOAD_B pulse cycle begins.
- The adder has one full cycle (SETTLE) to settle.
- Releasing the button produces no pulse.
- A bounce shorter than DEBOUNCE_CYCLES produces no pulse.

## Configuration
- OPSEQ_SELFTEST_EN defined:
  - In LOAD_A, selftest_start=1 enters SELFTEST and clears selftest_done and selftest_err. If selftest_start and a press coincide, selftest_start wins.
  - The sweep walks the counter {cin, b, a} from 0 to 2^(2·WIDTH+1)−1.
  - Each vector takes 2 cycles: cycle 1 drives a_out, b_out and cin_out; cycle 2 compares {cout_in,sum_in} with a+b+cin.
  - Any mismatch sets selftest_err.
  - After the last vector: selftest_done<=1, return to LOAD_A.
  - Total duration for WIDTH=3 is 256 cycles.
  - result_valid stays 0 during the sweep.
- OPSEQ_SELFTEST_EN undefined:
  - selftest_start is ignored.
  - selftest_done and selftest_err are tied to 0.
  - The SELFTEST state and the sweep counter are absent.

## Structure
- Shared package `adder_pkg` holds:
  - the state enum (LOAD_A, LOAD_B, SETTLE, SHOW, SELFTEST) with fixed 3-bit encodings;
  - the default WIDTH constant;
  - the default DEBOUNCE_CYCLES constant.
- One sub-module, `btn_debounce`: synchronizer, stability counter and rising-edge pulse generator, parameterized by DEBOUNCE_CYCLES.
- The adder is not instantiated inside this block. It is wired alongside at top level.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0, state_out=0.
- Normal add:
  - Set sw_in=3'b101 and press, then sw_in=3'b011 with cin_sw=1 and press, with the adder connected.
  - Required: result_out=4'b1001 and result_valid=1 two edges after the second pulse; state_out=3.
- Overflow boundary: A=7, B=7, cin=1 → result_out=4'b1111; SHOW press clears result_valid; state_out=0.
- Bounce: btn_next toggles every 3 cycles for 40 cycles, with DEBOUNCE_CYCLES=16 → no press pulse and no state change.
- Reset mid-operation: assert rst_n low in SETTLE → next state LOAD_A, result_valid=0, a_out=b_out=0.
- Self-test (OPSEQ_SELFTEST_EN):
  - Correct adder: pulse selftest_start → selftest_done=1 after 256 cycles, selftest_err=0.
  - Repeat with an adder stub that forces sum bit 1 to 0 → selftest_err=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder operand sequencer: FSM state encoding
// and the default operand width / debounce length.
package adder_pkg;

  localparam int DEFAULT_WIDTH           = 3;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Encodings are shown on LEDs, so they are fixed rather than left to the tool.
  typedef enum logic [2:0] {
    LOAD_A   = 3'd0,
    LOAD_B   = 3'd1,
    SETTLE   = 3'd2,
    SHOW     = 3'd3,
    SELFTEST = 3'd4
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted rising level.
module btn_debounce
  import adder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  logic             stable_d;

  // NOTE: every register here is written with <= so all flops sample the values
  // from before the edge; blocking assignments would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      stable_d <= stable;
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Level differed from the accepted one for DEBOUNCE_CYCLES cycles.
        stable <= sync_q[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Both terms are flops in this clock domain, so the pulse is glitch-free.
  assign press = stable & ~stable_d;

endmodule

// File: rtl/adder_operand_sequencer.sv
// Clocked front-end for an external ripple adder: loads A, B and carry-in from
// switches on debounced presses and registers the adder result for display.
// Optional built-in sweep self-test is enabled by defining OPSEQ_SELFTEST_EN.
module adder_operand_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             cin_sw,
  input  logic             btn_next,
  input  logic             selftest_start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             cin_out,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [WIDTH:0]   result_out,
  output logic             result_valid,
  output logic [2:0]       state_out,
  output logic             selftest_done,
  output logic             selftest_err
);

  state_t state;
  logic   press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .press (press)
  );

`ifdef OPSEQ_SELFTEST_EN
  localparam int VEC_W = 2 * WIDTH + 1;

  logic [VEC_W-1:0] vec;
  logic             check_phase;
  logic [WIDTH:0]   ref_sum;

  assign ref_sum = (WIDTH+1)'(a_out) + (WIDTH+1)'(b_out) + (WIDTH+1)'(cin_out);
`else
  logic unused_selftest_start;
  assign unused_selftest_start = selftest_start;
  assign selftest_done         = 1'b0;
  assign selftest_err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD_A;
      a_out        <= '0;
      b_out        <= '0;
      cin_out      <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
`ifdef OPSEQ_SELFTEST_EN
      vec           <= '0;
      check_phase   <= 1'b0;
      selftest_done <= 1'b0;
      selftest_err  <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD_A: begin
`ifdef OPSEQ_SELFTEST_EN
          // A start request takes priority over a coincident press.
          if (selftest_start) begin
            state         <= SELFTEST;
            vec           <= '0;
            check_phase   <= 1'b0;
            selftest_done <= 1'b0;
            selftest_err  <= 1'b0;
          end else
`endif
          if (press) begin
            a_out <= sw_in;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            b_out   <= sw_in;
            cin_out <= cin_sw;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          // Operands have been stable for a full cycle; capture the adder.
          result_out   <= {cout_in, sum_in};
          result_valid <= 1'b1;
          state        <= SHOW;
        end
        SHOW: begin
          if (press) begin
            result_valid <= 1'b0;
            state        <= LOAD_A;
          end
        end
`ifdef OPSEQ_SELFTEST_EN
        SELFTEST: begin
          if (!check_phase) begin
            {cin_out, b_out, a_out} <= vec;
            check_phase             <= 1'b1;
          end else begin
            if ({cout_in, sum_in} != ref_sum) begin
              selftest_err <= 1'b1;
            end
            check_phase <= 1'b0;
            if (&vec) begin
              selftest_done <= 1'b1;
              state         <= LOAD_A;
            end else begin
              vec <= vec + 1'b1;
            end
          end
        end
`endif
        default: state <= LOAD_A;
      endcase
    end
  end

  assign state_out = state;

endmodule
